clock_divider_prog: RTL and testbench

Runtime-programmable successor to the fixed-`DIVISOR` clock divider. Divides `clkin` by an integer `D` (2..2^WIDTH-1) loaded at run time, producing a near-50%-duty `clkout` plus a one-cycle `tick` strobe at each period start. Divisor changes are double-buffered and take effect only at a period boundary, so `clkout` never glitches or truncates. It feeds oscillator and envelope sample-rate generators that retune while running.

---
 rtl/clock_divider_prog.sv | 59 +++++
 tb/tb_clock_divider_prog.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: integer clock divider with a runtime divisor that is
// double-buffered and swapped in only at a period boundary (wrap or sync).
module clock_divider_prog #(
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 2
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_in,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_wr,
    output logic             div_pending,
    output logic [WIDTH-1:0] div_cur,
    output logic             clkout,
    output logic             tick
);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_DIV < 2 ? 2 : RESET_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d, cur_q, cur_d, nxt_q, nxt_d;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
    logic             wrap, bound;

    always_comb begin
        wrap   = cnt_q == cur_q - WIDTH'(1);
        bound  = sync_in | (en & wrap);
        cnt_d  = sync_in ? '0 : en ? (wrap ? '0 : cnt_q + WIDTH'(1)) : cnt_q;
        cur_d  = (bound & pend_q) ? nxt_q : cur_q;
        // a write on a boundary edge lands in the buffer after the swap
        pend_d = div_wr | (pend_q & ~bound);
        nxt_d  = div_wr ? ((div_in < TWO) ? TWO : div_in) : nxt_q;
        clk_d  = sync_in | (en ? (cnt_d < (cur_d - (cur_d >> 1))) : clk_q);
        tick_d = sync_in | (en & (cnt_d == '0));
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= RST_D - WIDTH'(1);
            cur_q  <= RST_D;
            nxt_q  <= RST_D;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cur_q  <= cur_d;
            nxt_q  <= nxt_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign div_pending = pend_q;
    assign div_cur     = cur_q;
    assign clkout      = clk_q;
    assign tick        = tick_q;
endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: table vectors, hand-written corner sequences and a
// randomized run, all checked against a period-position reference model.
module tb_clock_divider_prog;
    logic        clkin = 1'b0, rst_n = 1'b1, en = 1'b0, sync_in = 1'b0, div_wr = 1'b0;
    logic [15:0] div_in = '0;
    logic        div_pending, clkout, tick;
    logic [15:0] div_cur;
    int          checks = 0, errs = 0;
    int          m_pos, m_d, m_nd, m_pend, m_clk, m_tick;

    typedef struct {int e, s, w, d, c, t, cur, p;} vec_t;
    vec_t tbl[17];

    clock_divider_prog #(.WIDTH(16), .RESET_DIV(2)) dut (
        .clkin(clkin), .rst_n(rst_n), .en(en), .sync_in(sync_in), .div_in(div_in),
        .div_wr(div_wr), .div_pending(div_pending), .div_cur(div_cur),
        .clkout(clkout), .tick(tick)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 1; m_d = 2; m_nd = 2; m_pend = 0; m_clk = 0; m_tick = 0;
    endtask

    // Model tracks position within the current period and the divisor queue.
    task automatic model_step(input int e, input int s, input int w, input int d);
        bit b;
        b = (s != 0) || (e != 0 && m_pos == m_d - 1);
        if (s != 0) m_pos = 0;
        else if (e != 0) m_pos = b ? 0 : m_pos + 1;
        if (b && m_pend != 0) begin m_d = m_nd; m_pend = 0; end
        if (w != 0) begin m_nd = (d < 2) ? 2 : d; m_pend = 1; end
        m_tick = ((s != 0 || e != 0) && m_pos == 0) ? 1 : 0;
        if (s != 0 || e != 0) m_clk = (m_pos < (m_d + 1) / 2) ? 1 : 0;
    endtask

    task automatic step(input int e, input int s, input int w, input int d);
        en = e[0]; sync_in = s[0]; div_wr = w[0]; div_in = 16'(d);
        @(posedge clkin);
        model_step(e, s, w, d);
        #1;
        chk("m_clkout", int'(clkout), m_clk);
        chk("m_tick", int'(tick), m_tick);
        chk("m_div_cur", int'(div_cur), m_d);
        chk("m_pending", int'(div_pending), m_pend);
        en = 1'b0; sync_in = 1'b0; div_wr = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_clkout", int'(clkout), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_div_cur", int'(div_cur), 2);
        chk("rst_pending", int'(div_pending), 0);
        model_reset();
        repeat (2) @(posedge clkin);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int pat7[7];
        int pat6c[6];
        int pat6s[6];
        pat7  = '{1, 1, 1, 1, 0, 0, 0};
        pat6c = '{1, 1, 1, 0, 0, 0};
        pat6s = '{1, 1, 1, 0, 0, 0};
        tbl[0]  = '{1, 0, 0, 0, 1, 1, 2, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 2, 0};
        tbl[2]  = '{1, 0, 0, 0, 1, 1, 2, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 2, 0};
        tbl[4]  = '{1, 0, 1, 3, 1, 1, 2, 1};
        tbl[5]  = '{0, 1, 0, 0, 1, 1, 3, 0};
        tbl[6]  = '{1, 0, 0, 0, 1, 0, 3, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 3, 0};
        tbl[8]  = '{1, 0, 0, 0, 1, 1, 3, 0};
        tbl[9]  = '{1, 0, 0, 0, 1, 0, 3, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 3, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 3, 0};
        tbl[12] = '{1, 0, 1, 0, 1, 1, 3, 1};
        tbl[13] = '{1, 0, 1, 1, 1, 0, 3, 1};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 3, 1};
        tbl[15] = '{1, 0, 0, 0, 1, 1, 2, 0};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 2, 0};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].e, tbl[i].s, tbl[i].w, tbl[i].d);
            chk($sformatf("tbl%0d_clkout", i), int'(clkout), tbl[i].c);
            chk($sformatf("tbl%0d_tick", i), int'(tick), tbl[i].t);
            chk($sformatf("tbl%0d_div_cur", i), int'(div_cur), tbl[i].cur);
            chk($sformatf("tbl%0d_pending", i), int'(div_pending), tbl[i].p);
        end

        // boundary reload: D=4, write 7 while in the second cycle of the period
        step(1, 0, 1, 4);
        step(0, 1, 0, 0);
        chk("d4_first", int'(clkout), 1);
        chk("d4_cur", int'(div_cur), 4);
        step(1, 0, 0, 0);
        chk("d4_pos1", int'(clkout), 1);
        step(1, 0, 1, 7);
        chk("reload_pend", int'(div_pending), 1);
        chk("reload_pos2", int'(clkout), 0);
        step(1, 0, 0, 0);
        chk("reload_pos3", int'(clkout), 0);
        chk("reload_cur_old", int'(div_cur), 4);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 0);
            chk($sformatf("d7_clk%0d", i), int'(clkout), pat7[i]);
            chk($sformatf("d7_tick%0d", i), int'(tick), (i == 0) ? 1 : 0);
        end
        chk("d7_cur", int'(div_cur), 7);
        chk("d7_pend", int'(div_pending), 0);

        // two writes before a boundary: last one wins
        step(1, 0, 0, 0);
        step(1, 0, 1, 6);
        step(1, 0, 1, 9);
        repeat (4) step(1, 0, 0, 0);
        chk("ww_cur_before", int'(div_cur), 7);
        step(1, 0, 0, 0);
        chk("ww_cur", int'(div_cur), 9);

        // enable gating and sync restart at D=6
        step(1, 0, 1, 6);
        step(0, 1, 0, 0);
        chk("d6_cur", int'(div_cur), 6);
        chk("d6_tick", int'(tick), 1);
        repeat (2) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk($sformatf("gate_clk%0d", i), int'(clkout), 1);
            chk($sformatf("gate_tick%0d", i), int'(tick), 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk($sformatf("stretch_clk%0d", i), int'(clkout), 0);
        end
        step(1, 0, 0, 0);
        chk("stretch_wrap_tick", int'(tick), 1);
        repeat (4) step(1, 0, 0, 0);
        chk("pre_sync_clk", int'(clkout), 0);
        step(1, 1, 0, 0);
        chk("sync_clk", int'(clkout), 1);
        chk("sync_tick", int'(tick), 1);
        for (int i = 1; i < 7; i++) begin
            step(1, 0, 0, 0);
            chk($sformatf("post_sync_clk%0d", i), int'(clkout), (i == 6) ? 1 : pat6s[i]);
            chk($sformatf("post_sync_tick%0d", i), int'(tick), (i == 6) ? 1 : 0);
        end
        chk("pat6c_sanity", pat6c[3], 0);

        // asynchronous reset in the middle of a D=7 period
        step(1, 0, 1, 7);
        step(0, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        chk("mid_clk_high", int'(clkout), 1);
        chk("mid_cur", int'(div_cur), 7);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            chk($sformatf("rel_clk%0d", i), int'(clkout), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rel_tick%0d", i), int'(tick), (i % 2 == 0) ? 1 : 0);
        end

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            int e, s, w, d;
            e = ($urandom_range(0, 9) < 8) ? 1 : 0;
            s = ($urandom_range(0, 39) == 0) ? 1 : 0;
            w = ($urandom_range(0, 19) == 0) ? 1 : 0;
            d = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 12));
            step(e, s, w, d);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
